// File: rtl/counter_cmd_driver.sv
// counter_cmd_driver: command-side initiator for the loadable up/down mod-(MOD_MAX+1)
// counter. Takes LOAD / UP n / DOWN n / HOLD n commands over a valid/ready handshake
// and drives the counter's load/mode/data pins cycle by cycle. A shadow copy of the
// counter value (exp) tracks what the counter should hold on every edge.
//
// Optional feature: define CNT_DRV_CHECK_EN to compare cnt_q against the shadow value
// every cycle and raise a sticky err flag plus a saturating mismatch counter. When the
// macro is undefined, err and err_count are tied to 0 and cnt_q is unused.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid, cmd_ready  command handshake (ready only while idle)
//   cmd_op, cmd_arg       00 LOAD value / 01 UP n-1 / 10 DOWN n-1 / 11 HOLD n-1
//   cnt_load, cnt_mode,   to counter load, mode (1 = up), data_in
//   cnt_data
//   cnt_q                 from counter data_out
//   busy, done            running flag, one-cycle pulse when a command completes
//   err, err_count        sticky mismatch flag and saturating mismatch count
module counter_cmd_driver #(
    parameter int unsigned MOD_MAX  = 11,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [3:0]          cmd_arg,
    output logic                cnt_load,
    output logic                cnt_mode,
    output logic [3:0]          cnt_data,
    input  logic [3:0]          cnt_q,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam logic [3:0] MaxVal = 4'(MOD_MAX);
    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpUp   = 2'b01;
    localparam logic [1:0] OpDown = 2'b10;

    typedef enum logic {StIdle, StRun} state_t;

    state_t     state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic [3:0] exp_q, exp_next;
    logic       load_q, load_d;
    logic       mode_q, mode_d;
    logic [3:0] data_q, data_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Value the counter takes on the coming edge, given the pins driven right now.
    always_comb begin
        if (load_q) begin
            exp_next = data_q;
        end else if (mode_q) begin
            exp_next = (exp_q == MaxVal) ? 4'd0 : exp_q + 4'd1;
        end else begin
            exp_next = (exp_q == 4'd0) ? MaxVal : exp_q - 4'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        load_d      = load_q;
        mode_d      = mode_q;
        data_d      = data_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                // Hold: reload the value the counter is about to have.
                load_d = 1'b1;
                data_d = exp_next;
                if (cmd_valid && ready_q) begin
                    state_d     = StRun;
                    remaining_d = cmd_arg;
                    case (cmd_op)
                        OpLoad: begin
                            data_d      = cmd_arg;
                            remaining_d = 4'd0;
                        end
                        OpUp, OpDown: begin
                            load_d = 1'b0;
                            mode_d = (cmd_op == OpUp);
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (remaining_q == 4'd0) begin
                    // Switch to hold on the same edge as the final step: no extra count.
                    state_d = StIdle;
                    done_d  = 1'b1;
                    load_d  = 1'b1;
                    data_d  = exp_next;
                end else begin
                    remaining_d = remaining_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
        busy_d  = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= 4'd0;
            exp_q       <= 4'd0;
            load_q      <= 1'b1;
            mode_q      <= 1'b0;
            data_q      <= 4'd0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            exp_q       <= exp_next;
            load_q      <= load_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = ready_q;
    assign cnt_load  = load_q;
    assign cnt_mode  = mode_q;
    assign cnt_data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef CNT_DRV_CHECK_EN
    logic                err_q;
    logic [ERRCNT_W-1:0] err_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else if (cnt_q != exp_q) begin
            err_q <= 1'b1;
            if (err_count_q != {ERRCNT_W{1'b1}}) begin
                err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    assign err       = err_q;
    assign err_count = err_count_q;
`else
    logic unused_cnt_q;
    assign unused_cnt_q = ^cnt_q;
    assign err          = 1'b0;
    assign err_count    = '0;
`endif

endmodule

// File: tb/tb_counter_cmd_driver.sv
module tb_counter_cmd_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       cnt_load;
    logic       cnt_mode;
    logic [3:0] cnt_data;
    logic [3:0] cnt_q;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] err_count;

    logic [3:0] cnt_val;
    logic       force_en;
    logic [3:0] force_val;

    always #5 clk = ~clk;

    counter_cmd_driver #(.MOD_MAX(11), .ERRCNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cnt_load(cnt_load), .cnt_mode(cnt_mode),
        .cnt_data(cnt_data), .cnt_q(cnt_q), .busy(busy), .done(done), .err(err),
        .err_count(err_count)
    );

`ifdef CNT_DRV_CHECK_EN
    logic       r2, b2, d2, l2, m2, e2;
    logic [3:0] dt2;
    logic [1:0] ec2;
    counter_cmd_driver #(.MOD_MAX(11), .ERRCNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(r2),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cnt_load(l2), .cnt_mode(m2),
        .cnt_data(dt2), .cnt_q(cnt_q), .busy(b2), .done(d2), .err(e2),
        .err_count(ec2)
    );
`endif

    // Counter rules: up wraps 11->0, down wraps 0->11, other values by 4-bit arithmetic.
    function automatic logic [3:0] step(input logic [3:0] v, input logic up);
        if (up) return (v == 4'd11) ? 4'd0 : v + 4'd1;
        return (v == 4'd0) ? 4'd11 : v - 4'd1;
    endfunction

    // The counter the driver is attached to.
    always_ff @(posedge clk) begin
        if (rst)           cnt_val <= 4'd0;
        else if (cnt_load) cnt_val <= cnt_data;
        else               cnt_val <= step(cnt_val, cnt_mode);
    end

    assign cnt_q = force_en ? force_val : cnt_val;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] ref_val;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Issue one command from idle and follow it cycle by cycle against the model.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] arg, input bit noisy);
        int len;
        int waited;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        len = (op == 2'b00) ? 1 : int'(arg) + 1;
        check("busy_after_accept", int'(busy), 1);
        check("ready_after_accept", int'(cmd_ready), 0);
        check("cnt_after_accept", int'(cnt_q), int'(ref_val));
        for (int j = 1; j <= len; j++) begin
            // Valid asserted while running must be ignored.
            cmd_valid = noisy ? 1'($urandom) : 1'b0;
            cmd_op    = 2'($urandom);
            cmd_arg   = 4'($urandom);
            @(negedge clk);
            case (op)
                2'b00: ref_val = arg;
                2'b01: ref_val = step(ref_val, 1'b1);
                2'b10: ref_val = step(ref_val, 1'b0);
                default: ;
            endcase
            check("cnt_trace", int'(cnt_q), int'(ref_val));
            check("done_pulse", int'(done), int'(j == len));
            check("busy_run", int'(busy), int'(j != len));
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("cnt_hold", int'(cnt_q), int'(ref_val));
        check("done_clear", int'(done), 0);
        check("cnt_load_idle", int'(cnt_load), 1);
        check("err_clean", int'(err), 0);
        check("err_count_clean", int'(err_count), 0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] arg;
        logic [3:0] final_v;
    } cmd_vec_t;

    cmd_vec_t tbl[16];

    initial begin
        tbl[0]  = '{2'b00, 4'd9,  4'd9};
        tbl[1]  = '{2'b01, 4'd3,  4'd1};
        tbl[2]  = '{2'b00, 4'd2,  4'd2};
        tbl[3]  = '{2'b10, 4'd4,  4'd9};
        tbl[4]  = '{2'b00, 4'd14, 4'd14};
        tbl[5]  = '{2'b01, 4'd2,  4'd1};
        tbl[6]  = '{2'b11, 4'd3,  4'd1};
        tbl[7]  = '{2'b00, 4'd12, 4'd12};
        tbl[8]  = '{2'b01, 4'd0,  4'd13};
        tbl[9]  = '{2'b00, 4'd12, 4'd12};
        tbl[10] = '{2'b10, 4'd0,  4'd11};
        tbl[11] = '{2'b00, 4'd0,  4'd0};
        tbl[12] = '{2'b10, 4'd1,  4'd10};
        tbl[13] = '{2'b00, 4'd11, 4'd11};
        tbl[14] = '{2'b01, 4'd0,  4'd0};
        tbl[15] = '{2'b11, 4'd0,  4'd0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 4'd0;
        force_en  = 1'b0;
        force_val = 4'd0;
        ref_val   = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_cnt_load", int'(cnt_load), 1);
        check("rst_cnt_mode", int'(cnt_mode), 0);
        check("rst_cnt_data", int'(cnt_data), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_count", int'(err_count), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_cnt_load", int'(cnt_load), 1);
            check("idle_cnt_data", int'(cnt_data), 0);
            check("idle_cnt", int'(cnt_q), 0);
            check("idle_ready", int'(cmd_ready), 1);
            check("idle_err", int'(err), 0);
        end

        foreach (tbl[i]) begin
            run_cmd(tbl[i].op, tbl[i].arg, 1'b0);
            check("table_final", int'(cnt_q), int'(tbl[i].final_v));
        end

        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 4'($urandom), 1'b1);
        end

        // Reset during the third cycle of UP 7 aborts the command without done.
        run_cmd(2'b00, 4'd4, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_arg   = 4'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_cnt", int'(cnt_q), 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_val = 4'd0;
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_cnt", int'(cnt_q), 0);
        check("abort_load", int'(cnt_load), 1);
        check("abort_data", int'(cnt_data), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_abort_done", int'(done), 0);
            check("post_abort_cnt", int'(cnt_q), 0);
        end
        run_cmd(2'b01, 4'd2, 1'b0);
        check("post_abort_up", int'(cnt_q), 3);

`ifdef CNT_DRV_CHECK_EN
        force_val = 4'd5;
        force_en  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        force_en = 1'b0;
        check("force_err", int'(err), 1);
        check("force_err_count", int'(err_count), 2);
        @(negedge clk);
        @(negedge clk);
        check("err_sticky", int'(err), 1);
        check("err_count_hold", int'(err_count), 2);
        check("sat_count_2", int'(ec2), 2);
        force_en = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        force_en = 1'b0;
        @(negedge clk);
        check("err_count_5", int'(err_count), 5);
        check("sat_count_max", int'(ec2), 3);
        check("sat_err", int'(e2), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("err_rst_clear", int'(err), 0);
        check("err_count_rst_clear", int'(err_count), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_cmd_driver.md
Name: counter_cmd_driver

Overview:
- Command-side initiator for the loadable up/down mod-12 counter.
- Accepts high-level commands (LOAD, count UP n, count DOWN n, HOLD n) over a valid/ready handshake and generates the counter's load/mode/data_in pins cycle by cycle.
- Keeps a cycle-exact shadow model of the counter value and compares it against the counter output every cycle.
- Sits between the test/control logic and the counter; both blocks share clk and rst.

Parameters:
- MOD_MAX, 11, terminal count. Up wraps MOD_MAX->0; down wraps 0->MOD_MAX.
- ERRCNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  driver can accept a command; high only in IDLE.
- cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- cmd_arg  input  4  LOAD: value to load (0-15). UP/DOWN/HOLD: repeat count minus 1.
- cnt_load  output  1  to counter load.
- cnt_mode  output  1  to counter mode; 1 = up.
- cnt_data  output  4  to counter data_in.
- cnt_q  input  4  from counter data_out.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on the RUN->IDLE transition.
- err  output  1  sticky mismatch flag.
- err_count  output  ERRCNT_W  number of mismatched cycles; saturates at all-ones.

Behaviour:
- All outputs are registered.
- Reset values: cnt_load=1, cnt_mode=0, cnt_data=0, cmd_ready=1, busy=0, done=0, err=0, err_count=0. Internal state: exp=0, state=IDLE, remaining=0.
- Reset mid-command aborts the command with no done pulse. The counter also resets to 0, so the model stays aligned.

Shadow model:
- exp updates on every edge from the currently driven cnt_* pins, using exactly the counter rules:
  - load=1: exp <= cnt_data.
  - up: exp <= (exp==MOD_MAX) ? 0 : exp+1, 4-bit wrap.
  - down: exp <= (exp==0) ? MOD_MAX : exp-1.
- Out-of-range loaded values (12-15) are modelled as-is. Up from 12 goes to 13, and 15 goes to 0 by 4-bit wrap. Down from 12 goes to 11.

FSM IDLE:
- Drives cnt_load=1 and cnt_data=exp, so the counter holds its value.
- cmd_ready=1.
- On cmd_valid (handshake cmd_valid & cmd_ready), at edge k:
  - LOAD: cnt_load<=1, cnt_data<=cmd_arg, remaining<=0.
  - UP/DOWN: cnt_load<=0, cnt_mode<=op==UP, remaining<=cmd_arg.
  - HOLD: cnt_load<=1, cnt_data<=exp_next, remaining<=cmd_arg.
  - In all cases state<=RUN.
- The counter acts on the command at edge k+1.

FSM RUN:
- Each edge decrements remaining.
- When remaining==0 at an edge:
  - state<=IDLE, done<=1.
  - cnt_load<=1, cnt_data<=exp_next, where exp_next is the value the counter takes on that same edge.
  - This gives a seamless hold with no extra count.
- An UP/DOWN command with arg N therefore produces exactly N+1 counter steps. LOAD lasts one cycle.
- Back-to-back commands: cmd_ready is low throughout RUN. There is at least one IDLE (hold) cycle between commands.
- cmd_valid in RUN is ignored; the command is held by the sender per valid/ready rules.

Optional Feature:
- Macro: CNT_DRV_CHECK_EN.
- Defined:
  - Every cycle with rst low, if cnt_q != exp: err<=1 and err_count increments, saturating.
  - err clears only on rst.
- Undefined:
  - No compare logic.
  - err and err_count are tied to 0; cnt_q is unused.

Test Plan:
- Reset then idle for 5 cycles -> cnt_load=1, cnt_data=0, counter stays 0, cmd_ready=1, err=0.
- LOAD 9, then UP arg=3 -> counter 9,10,11,0,1 then holds at 1. done pulses once. Exactly 4 steps.
- LOAD 2, then DOWN arg=4 -> 2,1,0,11,10,9, then holds at 9. No extra step at the RUN->IDLE edge.
- LOAD 14, then UP arg=2 -> 14,15,0,1. exp tracks 4-bit wrap. err=0 (check enabled).
- rst asserted in the third cycle of UP arg=7 -> next cycle state IDLE, counter 0, no done, cmd_ready=1.
- With CNT_DRV_CHECK_EN, force cnt_q to 5 while exp=3 for 2 cycles -> err=1 (sticky), err_count=2. With err_count near saturation (ERRCNT_W=2), further mismatches hold it at 3.
